// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package mips_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_datapath.sv
// Magnitude accumulator for shift-add multiply / restoring divide, plus sign fix-up.
module mdu_datapath
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             CLK,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   oper_q;
  logic [WIDTH-1:0]   raw_a_q;
  logic               is_div_q, neg_q_q, neg_r_q, dz_q;

  logic               is_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    is_signed = (mdu_op_t'(op) == OP_MULT) || (mdu_op_t'(op) == OP_DIV);
    sa        = is_signed & opA[WIDTH-1];
    sb        = is_signed & opB[WIDTH-1];
    mag_a     = sa ? -opA : opA;
    mag_b     = sb ? -opB : opB;
  end

  // Multiplier lives in the low half and is consumed LSB-first as the product shifts in.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, oper_q};
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      is_div_q <= op[1];
      neg_q_q  <= sa ^ sb;
      neg_r_q  <= sa;
      dz_q     <= op[1] && (opB == '0);
      raw_a_q  <= opA;
      acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
      oper_q   <= op[1] ? mag_b : mag_a;
    end else if (step) begin
      if (!is_div_q)
        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
      else if (!trial[WIDTH])
        acc_q <= {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_q <= {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    quot_fix = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    div_zero = dz_q;
    if (dz_q) begin
      res_hi = raw_a_q;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: control FSM, step counter and HI/LO output registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, fix, busy_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_dz;

  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .CLK      (CLK),
    .load     (load),
    .step     (step),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (res_dz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= fix;
      div_zero <= fix & res_dz;
      if (fix) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic reference.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0, opB = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output bit edz);
    longint          sp, sq, sr;
    longint unsigned up;
    edz = 0;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = sp;
      end
      2'b01: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        {eh, el} = up;
      end
      default: begin
        if (b == 0) begin
          edz = 1; eh = a; el = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // Drive at posedge+1; the next edge is E0.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit glitch);
    logic [31:0] eh, el;
    bit          edz, busy_ok;
    int          first;
    ref_model(o, a, b, eh, el, edz);
    start = 1; op = o; opA = a; opB = b;
    @(posedge CLK); #1;
    start = 0; op = 2'($urandom); opA = $urandom; opB = $urandom;
    check("busy_e0", busy, 1);
    check("done_clr", done, 0);
    first = 0; busy_ok = 1;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      if (glitch && (n == 5 || n == 20)) start = 1;
      @(posedge CLK); #1;
      start = 0;
      if (done) first = n;
      else if (!busy) busy_ok = 0;
    end
    check("latency", first, 33);
    check("busy_held", busy_ok, 1);
    check("busy_end", busy, 0);
    check("hi", hi, eh);
    check("lo", lo, el);
    check("div_zero", div_zero, edz);
  endtask

  task automatic count_dones(input int cycles, input string tag);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (done) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] corner [6];
    corner[0] = 32'h8000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h0;
    corner[3] = 32'h1;         corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h2;

    RST = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    RST = 0;
    @(posedge CLK); #1;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    check("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mult_m1m1", {hi, lo}, 64'h0000_0000_0000_0001);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg7by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b11, 32'd100, 32'd7, 0);
    check("divu_100by7", {hi, lo}, 64'h0000_0002_0000_000E);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {hi, lo, 31'd0, div_zero}, {64'h0000_0000_8000_0000, 32'd0});
    do_op(2'b11, 32'h1234, 32'h0, 0);
    check("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    do_op(2'b10, 32'hFFFF_FF00, 32'h0, 0);
    do_op(2'b00, 32'd6, 32'd7, 0);
    check("dz_cleared", div_zero, 0);

    // Busy-time start pulses are dropped; only one completion follows.
    do_op(2'b00, 32'h0001_0003, 32'hFFFF_0007, 1);
    count_dones(40, "no_extra_done");

    // Back-to-back: start during the done cycle is accepted.
    do_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    do_op(2'b10, 32'h8765_4321, 32'h0000_0123, 0);

    // Reset mid-operation discards the in-flight divide.
    start = 1; op = 2'b10; opA = 32'h0000_0077; opB = 32'd3;
    @(posedge CLK); #1;
    start = 0;
    repeat (9) @(posedge CLK);
    #1;
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    count_dones(40, "midrst_no_done");
    do_op(2'b11, 32'd1000, 32'd33, 0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      do_op(2'($urandom), ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
